// File: rtl/npc_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// npc_mem_arbiter_pkg
// Shared types and constants for the npc memory arbiter:
//   - arb_state_e : FSM encoding (IDLE / REQ / WAIT, 2 bits)
//   - arb_owner_e : which requester owns the bus transaction (IF / LSU)
//   - ARB_TIMEOUT_CYC : default watchdog limit
//   - arb_hold()  : stall-request decode shared by the top level
// -----------------------------------------------------------------------------
package npc_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_REQ  = 2'b01,
    ARB_WAIT = 2'b10
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IF  = 1'b0,
    ARB_OWN_LSU = 1'b1
  } arb_owner_e;

  localparam int unsigned ARB_TIMEOUT_CYC = 32'd255;

  // The core must stall whenever a request is pending or memory has not answered yet.
  function automatic logic arb_hold(input arb_state_e st, input logic any_req, input logic rvalid);
    logic hold_v;
    case (st)
      ARB_IDLE: hold_v = any_req;
      ARB_REQ:  hold_v = 1'b1;
      ARB_WAIT: hold_v = ~rvalid;
      default:  hold_v = 1'b0;
    endcase
    return hold_v;
  endfunction

endpackage

// File: rtl/npc_arb_wdog.sv
// -----------------------------------------------------------------------------
// npc_arb_wdog
// Load/count/expire watchdog for the memory arbiter. Only instantiated when
// NPC_MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart the count (transaction accepted from IDLE)
//   en        : count this cycle (arbiter in REQ or WAIT)
//   expired   : high in the LIMIT-th counted cycle of a transaction
// -----------------------------------------------------------------------------
module npc_arb_wdog #(
  parameter int unsigned LIMIT = 32'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 32'd2) ? 32'd1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 32'd1);
  localparam logic [CW-1:0] ONE  = CW'(32'd1);
  localparam logic [CW-1:0] ZERO = CW'(32'd0);

  logic [CW-1:0] cnt_r;

  // The first counted cycle sits at zero, so LIMIT cycles end when the count reads LIMIT-1.
  assign expired = en & (cnt_r == LAST);

  // Cycle counter: cleared on a new transaction, saturates at the expiry value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= ZERO;
    end else if (clr) begin
      cnt_r <= ZERO;
    end else if (en && !expired) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// npc_mem_arbiter
// Shares one memory bus between instruction fetch (IF) and the load/store
// unit (LSU) of the npc core. One bus transaction is outstanding at a time;
// LSU wins simultaneous requests. hold_flag_o stalls the core while busy.
//
// Optional feature: define NPC_MEM_ARB_TIMEOUT_EN to enable a watchdog that
// aborts a transaction after TIMEOUT_CYC cycles in REQ/WAIT (owner rvalid with
// rdata 0 plus a one-cycle err_o). Without it, err_o is tied low.
//
// Ports:
//   clk, rst                          : clock, async active-high reset
//   if_req/if_addr                    : fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata         : fetch accept pulse, data pulse, data
//   lsu_req/lsu_we/lsu_addr/
//   lsu_wdata/lsu_wstrb               : load/store request (held until lsu_gnt)
//   lsu_gnt/lsu_rvalid/lsu_rdata      : LSU accept pulse, data/ack pulse, data
//   bus_req/bus_we/bus_addr/
//   bus_wdata/bus_wstrb               : bus command (from latched registers)
//   bus_gnt/bus_rvalid/bus_rdata      : bus accept, response, response data
//   hold_flag_o                       : stall request to the core
//   err_o                             : watchdog abort pulse
// -----------------------------------------------------------------------------
module npc_mem_arbiter
  import npc_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32'd64,
  parameter int unsigned DATA_W      = 32'd64,
  parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                hold_flag_o,
  output logic                err_o
);

  localparam int unsigned STRB_W = DATA_W / 32'd8;

  arb_state_e          state_r;
  arb_state_e          state_nxt_s;
  arb_owner_e          owner_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [STRB_W-1:0]   wstrb_r;
  logic [DATA_W-1:0]   if_rdata_r;
  logic [DATA_W-1:0]   lsu_rdata_r;

  logic                take_lsu_s;
  logic                take_if_s;
  logic                gnt_s;
  logic                rsp_s;
  logic [DATA_W-1:0]   rsp_data_s;
  logic                err_s;
  logic                expire_s;
  logic                busy_s;

  assign busy_s = (state_r == ARB_REQ) | (state_r == ARB_WAIT);

`ifdef NPC_MEM_ARB_TIMEOUT_EN
  npc_arb_wdog #(
    .LIMIT   (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (take_lsu_s | take_if_s),
    .en      (busy_s),
    .expired (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // Next-state and per-cycle event decode; a real response beats a same-cycle expiry.
  always_comb begin
    state_nxt_s = state_r;
    take_lsu_s  = 1'b0;
    take_if_s   = 1'b0;
    gnt_s       = 1'b0;
    rsp_s       = 1'b0;
    rsp_data_s  = {DATA_W{1'b0}};
    err_s       = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (lsu_req) begin
          take_lsu_s  = 1'b1;
          state_nxt_s = ARB_REQ;
        end else if (if_req) begin
          take_if_s   = 1'b1;
          state_nxt_s = ARB_REQ;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        if (expire_s) begin
          rsp_s       = 1'b1;
          err_s       = 1'b1;
          state_nxt_s = ARB_IDLE;
        end else if (bus_gnt) begin
          gnt_s       = 1'b1;
          state_nxt_s = ARB_WAIT;
        end else begin
          state_nxt_s = ARB_REQ;
        end
      end
      ARB_WAIT: begin
        if (bus_rvalid) begin
          rsp_s       = 1'b1;
          rsp_data_s  = bus_rdata;
          state_nxt_s = ARB_IDLE;
        end else if (expire_s) begin
          rsp_s       = 1'b1;
          err_s       = 1'b1;
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_WAIT;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // State, owner and latched bus command; the command is frozen for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ARB_IDLE;
      owner_r <= ARB_OWN_IF;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      wstrb_r <= {STRB_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (take_lsu_s) begin
        owner_r <= ARB_OWN_LSU;
        we_r    <= lsu_we;
        addr_r  <= lsu_addr;
        wdata_r <= lsu_wdata;
        // Reads carry no byte enables on the bus.
        wstrb_r <= lsu_we ? lsu_wstrb : {STRB_W{1'b0}};
      end else if (take_if_s) begin
        owner_r <= ARB_OWN_IF;
        we_r    <= 1'b0;
        addr_r  <= if_addr;
        wdata_r <= {DATA_W{1'b0}};
        wstrb_r <= {STRB_W{1'b0}};
      end else begin
        owner_r <= owner_r;
        we_r    <= we_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
        wstrb_r <= wstrb_r;
      end
    end
  end

  // Last delivered read data per requester, so the non-owner's rdata stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_r  <= {DATA_W{1'b0}};
      lsu_rdata_r <= {DATA_W{1'b0}};
    end else if (rsp_s && (owner_r == ARB_OWN_LSU)) begin
      if_rdata_r  <= if_rdata_r;
      lsu_rdata_r <= rsp_data_s;
    end else if (rsp_s) begin
      if_rdata_r  <= rsp_data_s;
      lsu_rdata_r <= lsu_rdata_r;
    end else begin
      if_rdata_r  <= if_rdata_r;
      lsu_rdata_r <= lsu_rdata_r;
    end
  end

  // Steer the one-cycle events to the owner; response data passes through in its cycle.
  always_comb begin
    if_gnt      = gnt_s & (owner_r == ARB_OWN_IF);
    lsu_gnt     = gnt_s & (owner_r == ARB_OWN_LSU);
    if_rvalid   = rsp_s & (owner_r == ARB_OWN_IF);
    lsu_rvalid  = rsp_s & (owner_r == ARB_OWN_LSU);
    if_rdata    = if_rvalid ? rsp_data_s : if_rdata_r;
    lsu_rdata   = lsu_rvalid ? rsp_data_s : lsu_rdata_r;
    bus_req     = (state_r == ARB_REQ);
    bus_we      = we_r;
    bus_addr    = addr_r;
    bus_wdata   = wdata_r;
    bus_wstrb   = wstrb_r;
    // Stall is forced low during reset so every output reads zero.
    hold_flag_o = ~rst & arb_hold(state_r, if_req | lsu_req, bus_rvalid);
    err_o       = err_s;
  end

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_npc_mem_arbiter
// Directed bench with a response scoreboard: every expected IF/LSU response is
// queued when the bus stimulus for it is issued; a negedge monitor pops and
// compares whenever the arbiter presents if_rvalid / lsu_rvalid / err_o.
// Cycle-exact checks (gnt, bus command, hold flag) are made inline.
// -----------------------------------------------------------------------------
module tb_npc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = 64'h0;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [63:0] lsu_addr = 64'h0;
  logic [63:0] lsu_wdata = 64'h0;
  logic [7:0]  lsu_wstrb = 8'h0;
  logic        lsu_gnt, lsu_rvalid;
  logic [63:0] lsu_rdata;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [63:0] bus_rdata = 64'h0;
  logic        hold_flag_o, err_o;

  npc_mem_arbiter #(
    .ADDR_W      (64),
    .DATA_W      (64),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .lsu_req     (lsu_req),
    .lsu_we      (lsu_we),
    .lsu_addr    (lsu_addr),
    .lsu_wdata   (lsu_wdata),
    .lsu_wstrb   (lsu_wstrb),
    .lsu_gnt     (lsu_gnt),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_rdata   (lsu_rdata),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .hold_flag_o (hold_flag_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lsu;
    logic [63:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare each presented response against the queue head.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (if_rvalid || lsu_rvalid || err_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {61'h0, if_rvalid, lsu_rvalid, err_o}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_one_hot", 64'(if_rvalid ^ lsu_rvalid), 64'h1);
        chk("rsp_owner", 64'(lsu_rvalid), 64'(e.lsu));
        chk("rsp_data", e.lsu ? lsu_rdata : if_rdata, e.data);
        chk("rsp_err", 64'(err_o), 64'(e.err));
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req, 64'h0);
    chk("rst_hold", hold_flag_o, 64'h0);
    chk("rst_if_rdata", if_rdata, 64'h0);
    chk("rst_bus_addr", bus_addr, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    // T1: single fetch, bus grants at once, data one cycle later
    if_req = 1'b1; if_addr = 64'h8000_0000; bus_gnt = 1'b1;
    @(negedge clk);
    chk("t1_hold_idle", hold_flag_o, 64'h1);
    chk("t1_bus_req_c0", bus_req, 64'h0);
    cyc();
    @(negedge clk);
    chk("t1_if_gnt", if_gnt, 64'h1);
    chk("t1_bus_req", bus_req, 64'h1);
    chk("t1_bus_addr", bus_addr, 64'h8000_0000);
    chk("t1_bus_we", bus_we, 64'h0);
    chk("t1_bus_wstrb", bus_wstrb, 64'h0);
    cyc();
    if_req = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h13;
    exp_q.push_back('{1'b0, 64'h13, 1'b0});
    @(negedge clk);
    chk("t1_if_rvalid", if_rvalid, 64'h1);
    chk("t1_hold_low", hold_flag_o, 64'h0);
    cyc();
    bus_rvalid = 1'b0; bus_rdata = 64'h0;

    // T2: simultaneous IF and LSU load, LSU first
    if_req = 1'b1; if_addr = 64'h8000_0100;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_1000; bus_gnt = 1'b1;
    cyc();
    @(negedge clk);
    chk("t2_lsu_gnt", lsu_gnt, 64'h1);
    chk("t2_if_gnt_0", if_gnt, 64'h0);
    chk("t2_bus_addr_lsu", bus_addr, 64'h8000_1000);
    chk("t2_bus_we_lsu", bus_we, 64'h0);
    cyc();
    lsu_req = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h1111_2222;
    exp_q.push_back('{1'b1, 64'h1111_2222, 1'b0});
    cyc();
    bus_rvalid = 1'b0; bus_rdata = 64'h0; bus_gnt = 1'b1;
    @(negedge clk);
    chk("t2_idle_bus_req", bus_req, 64'h0);
    chk("t2_idle_hold", hold_flag_o, 64'h1);
    cyc();
    @(negedge clk);
    chk("t2_if_gnt", if_gnt, 64'h1);
    chk("t2_bus_addr_if", bus_addr, 64'h8000_0100);
    chk("t2_bus_we_if", bus_we, 64'h0);
    cyc();
    if_req = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'hAAAA_0000_0000_0093;
    exp_q.push_back('{1'b0, 64'hAAAA_0000_0000_0093, 1'b0});
    cyc();
    bus_rvalid = 1'b0; bus_rdata = 64'h0;

    // T3: store with bus_gnt delayed three cycles
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_2000;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wstrb = 8'h0F;
    cyc();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("t3_bus_req_held", bus_req, 64'h1);
      chk("t3_lsu_gnt_0", lsu_gnt, 64'h0);
      chk("t3_bus_we", bus_we, 64'h1);
      chk("t3_bus_addr", bus_addr, 64'h8000_2000);
      chk("t3_bus_wdata", bus_wdata, 64'hDEAD_BEEF);
      chk("t3_bus_wstrb", bus_wstrb, 64'h0F);
      chk("t3_hold", hold_flag_o, 64'h1);
      cyc();
      if (i == 3) bus_gnt = 1'b1;
    end
    @(negedge clk);
    chk("t3_bus_req_4th", bus_req, 64'h1);
    chk("t3_lsu_gnt", lsu_gnt, 64'h1);
    cyc();
    lsu_req = 1'b0; lsu_we = 1'b0; bus_gnt = 1'b0;
    @(negedge clk);
    chk("t3_hold_wait", hold_flag_o, 64'h1);
    chk("t3_no_ack_yet", lsu_rvalid, 64'h0);
    cyc();
    bus_rvalid = 1'b1; bus_rdata = 64'h0;
    exp_q.push_back('{1'b1, 64'h0, 1'b0});
    @(negedge clk);
    chk("t3_hold_ack", hold_flag_o, 64'h0);
    cyc();
    bus_rvalid = 1'b0;

    // T4: stray bus_rvalid in IDLE
    bus_rvalid = 1'b1; bus_rdata = 64'hFFFF;
    @(negedge clk);
    chk("t4_if_rvalid", if_rvalid, 64'h0);
    chk("t4_lsu_rvalid", lsu_rvalid, 64'h0);
    chk("t4_gnts", {if_gnt, lsu_gnt}, 64'h0);
    chk("t4_hold", hold_flag_o, 64'h0);
    chk("t4_if_rdata_held", if_rdata, 64'hAAAA_0000_0000_0093);
    chk("t4_lsu_rdata_held", lsu_rdata, 64'h0);
    cyc();
    bus_rvalid = 1'b0; bus_rdata = 64'h0;
    @(negedge clk);
    chk("t4_still_idle", bus_req, 64'h0);
    cyc();

    // T5: reset while waiting, late response ignored, next fetch served
    if_req = 1'b1; if_addr = 64'h8000_0040; bus_gnt = 1'b1;
    cyc();
    cyc();
    if_req = 1'b0; bus_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_bus_req", bus_req, 64'h0);
    chk("t5_rst_hold", hold_flag_o, 64'h0);
    chk("t5_rst_pulses", {if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, err_o}, 64'h0);
    chk("t5_rst_bus_addr", bus_addr, 64'h0);
    chk("t5_rst_if_rdata", if_rdata, 64'h0);
    chk("t5_rst_lsu_rdata", lsu_rdata, 64'h0);
    cyc();
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h55;
    @(negedge clk);
    chk("t5_late_rvalid", if_rvalid, 64'h0);
    chk("t5_late_bus_req", bus_req, 64'h0);
    chk("t5_late_hold", hold_flag_o, 64'h0);
    cyc();
    bus_rvalid = 1'b0; bus_rdata = 64'h0;
    if_req = 1'b1; if_addr = 64'h8000_0080; bus_gnt = 1'b1;
    cyc();
    @(negedge clk);
    chk("t5_if_gnt", if_gnt, 64'h1);
    chk("t5_bus_addr", bus_addr, 64'h8000_0080);
    cyc();
    if_req = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h37;
    exp_q.push_back('{1'b0, 64'h37, 1'b0});
    cyc();
    bus_rvalid = 1'b0; bus_rdata = 64'h0;

`ifdef NPC_MEM_ARB_TIMEOUT_EN
    // T6: bus never grants; watchdog aborts after 8 cycles
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_3000;
    cyc();
    lsu_req = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("t6_bus_req", bus_req, 64'h1);
      chk("t6_err_0", err_o, 64'h0);
      cyc();
    end
    exp_q.push_back('{1'b1, 64'h0, 1'b1});
    @(negedge clk);
    chk("t6_err", err_o, 64'h1);
    chk("t6_lsu_rvalid", lsu_rvalid, 64'h1);
    cyc();
    @(negedge clk);
    chk("t6_idle_bus_req", bus_req, 64'h0);
    chk("t6_idle_hold", hold_flag_o, 64'h0);
    cyc();
`endif

    repeat (2) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
